// File: rtl/draw_engine.sv
// Pixel rasterizer for bricks, paddle and ball on the 160x120 framebuffer.
// One pixel per clock; busy holds the game controller in its drawing state.
module draw_engine #(
  parameter int BRICK_W  = 36,
  parameter int BRICK_H  = 6,
  parameter int PADDLE_W = 24,
  parameter int PADDLE_Y = 112,
  parameter int BALL_S   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ld_draw,
  input  logic [7:0] paddle_x,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a valid code different from done_cmd
  // SETUP | shape decode, position latch, pixel (0,0) loaded
  // SCAN  | one pixel per cycle, row-major
  // DONE  | record finished command
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t     state, state_nxt;
  logic [4:0] cmd_q, done_cmd;
  logic [7:0] pad_drawn, ball_drawn_x;
  logic [6:0] ball_drawn_y;
  logic [8:0] org_x, org_y;
  logic [5:0] w_m1, cx, nxt_cx;
  logic [2:0] h_m1, cy, nxt_cy;

  logic [8:0] s_org_x, s_org_y, pix_x, pix_y;
  logic [5:0] s_w_m1;
  logic [2:0] s_h_m1, s_col;
  logic       cmd_valid, start, last, clip;
  logic       is_remove, is_brick;
  logic [3:0] brick_idx;
  logic [1:0] brick_r, brick_c;

  assign cmd_valid = (ld_draw >= 5'd1) && (ld_draw <= 5'd28);
  assign start     = cmd_valid && (ld_draw != done_cmd);
  assign busy      = !reset && ((state != IDLE) || start);

  assign is_remove = (cmd_q >= 5'd17) && (cmd_q <= 5'd28);
  assign is_brick  = ((cmd_q >= 5'd1) && (cmd_q <= 5'd12)) || is_remove;
  assign brick_idx = is_remove ? 4'(cmd_q - 5'd17) : 4'(cmd_q - 5'd1);
  assign brick_r   = brick_idx[3:2];
  assign brick_c   = brick_idx[1:0];

  // Draw commands take the live position; erase uses what was last drawn.
  always_comb begin
    s_org_x = 9'd0;
    s_org_y = 9'd0;
    s_w_m1  = 6'd0;
    s_h_m1  = 3'd0;
    s_col   = 3'b000;
    if (is_brick) begin
      s_org_x = 9'd2 + 9'd40 * {7'd0, brick_c};
      s_org_y = 9'd10 + 9'd10 * {7'd0, brick_r};
      s_w_m1  = 6'(BRICK_W - 1);
      s_h_m1  = 3'(BRICK_H - 1);
      if (!is_remove) begin
        case (brick_r)
          2'd0:    s_col = 3'b100;
          2'd1:    s_col = 3'b110;
          default: s_col = 3'b010;
        endcase
      end
    end else if (cmd_q == 5'd13 || cmd_q == 5'd14) begin
      s_org_x = {1'b0, (cmd_q == 5'd14) ? paddle_x : pad_drawn};
      s_org_y = 9'(PADDLE_Y);
      s_w_m1  = 6'(PADDLE_W - 1);
      s_h_m1  = 3'd2;
      s_col   = (cmd_q == 5'd14) ? 3'b111 : 3'b000;
    end else if (cmd_q == 5'd15 || cmd_q == 5'd16) begin
      s_org_x = {1'b0, (cmd_q == 5'd16) ? ball_x : ball_drawn_x};
      s_org_y = {2'b00, (cmd_q == 5'd16) ? ball_y : ball_drawn_y};
      s_w_m1  = 6'(BALL_S - 1);
      s_h_m1  = 3'(BALL_S - 1);
      s_col   = (cmd_q == 5'd16) ? 3'b111 : 3'b000;
    end
  end

  assign last   = (cx == w_m1) && (cy == h_m1);
  assign nxt_cx = (cx == w_m1) ? 6'd0 : cx + 6'd1;
  assign nxt_cy = (cx == w_m1) ? cy + 3'd1 : cy;

  // Outputs are registered, so each edge loads the pixel shown next cycle.
  assign pix_x = (state == SETUP) ? s_org_x : org_x + {3'd0, nxt_cx};
  assign pix_y = (state == SETUP) ? s_org_y : org_y + {6'd0, nxt_cy};
  assign clip  = (pix_x > 9'd159) || (pix_y > 9'd119);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_q        <= 5'd0;
      done_cmd     <= 5'd0;
      pad_drawn    <= 8'd68;
      ball_drawn_x <= 8'd79;
      ball_drawn_y <= 7'd60;
      org_x        <= 9'd0;
      org_y        <= 9'd0;
      w_m1         <= 6'd0;
      h_m1         <= 3'd0;
      cx           <= 6'd0;
      cy           <= 3'd0;
      x            <= 8'd0;
      y            <= 7'd0;
      colour       <= 3'b000;
      plot         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_draw == 5'd0)
        done_cmd <= 5'd0;
      else if (state == DONE)
        done_cmd <= cmd_q;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (start) cmd_q <= ld_draw;
        end
        SETUP: begin
          org_x  <= s_org_x;
          org_y  <= s_org_y;
          w_m1   <= s_w_m1;
          h_m1   <= s_h_m1;
          cx     <= 6'd0;
          cy     <= 3'd0;
          x      <= pix_x[7:0];
          y      <= pix_y[6:0];
          colour <= s_col;
          plot   <= !clip;
          if (cmd_q == 5'd14) pad_drawn <= paddle_x;
          if (cmd_q == 5'd16) begin
            ball_drawn_x <= ball_x;
            ball_drawn_y <= ball_y;
          end
        end
        SCAN: begin
          if (last) begin
            plot <= 1'b0;
          end else begin
            cx   <= nxt_cx;
            cy   <= nxt_cy;
            x    <= pix_x[7:0];
            y    <= pix_y[6:0];
            plot <= !clip;
          end
        end
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule
